// File: rtl/ps2_key_sequencer.sv
// PS/2 receive sequencer: folds E0/F0 prefix bytes into single key events
// and queues them in a first-word fall-through FIFO that backpressures ps2_rx.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [9:0]      head;

  logic            emit, emit_ext, emit_brk;
  logic            full, empty, pop, push;

  // Prefix FSM state and idle-timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_done_tick) begin
      // A byte arriving on the timeout cycle wins over the timeout
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hE0)      state_d = S_E0;
          else if (rx_data == 8'hF0) state_d = S_F0;
          else                       emit = 1'b1;
        end
        S_E0: begin
          if (rx_data == 8'hF0)      state_d = S_E0F0;
          else if (rx_data == 8'hE0) state_d = S_E0;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        S_F0: begin
          if (rx_data == 8'hF0)      state_d = S_F0;
          else if (rx_data == 8'hE0) state_d = S_E0F0;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          if (rx_data == 8'hE0 || rx_data == 8'hF0) state_d = S_E0F0;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
            state_d  = IDLE;
          end
        end
      endcase
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && key_ready;
  assign push  = emit && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (emit && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {emit_ext, emit_brk, rx_data};
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_en     = !full;
  assign key_valid = !empty;
  assign key_code  = empty ? 8'h00 : head[7:0];
  assign key_ext   = empty ? 1'b0  : head[9];
  assign key_brk   = empty ? 1'b0  : head[8];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: directed byte sequences push expected
// events into a queue; a monitor pops and compares on every accepted head event.
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_en(rx_en), .key_valid(key_valid), .key_ready(key_ready),
    .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every head event the consumer accepts must match the scoreboard
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got ext=%0b brk=%0b code=%0h, none expected",
                 key_ext, key_brk, key_code);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({key_ext, key_brk, key_code} !== e) begin
          fails++;
          $display("FAIL event: got ext=%0b brk=%0b code=%0h expected ext=%0b brk=%0b code=%0h",
                   key_ext, key_brk, key_code, e[9], e[8], e[7:0]);
        end
      end
    end
  end

  // Called at posedge+1; the byte is sampled on the next rising edge
  task automatic send(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    key_ready    = 1'b1;
    idle(3);
    check("reset_rx_en",     rx_en,     1);
    check("reset_key_valid", key_valid, 0);
    check("reset_key_code",  key_code,  0);
    check("reset_ext_brk",   {key_ext, key_brk}, 0);
    check("reset_overflow",  overflow,  0);
    reset = 1'b0;
    idle(1);

    // Plain code with one-cycle latency
    expect_ev(0, 0, 8'h1C);
    rx_data = 8'h1C; rx_done_tick = 1'b1;
    @(negedge clk);
    check("latency_before", key_valid, 0);
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    check("latency_after", key_valid, 1);
    idle(2);

    expect_ev(0, 1, 8'h1C); send(8'hF0); send(8'h1C); idle(2);
    expect_ev(1, 1, 8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    expect_ev(1, 0, 8'h75); send(8'hE0); send(8'h75); idle(2);
    expect_ev(1, 0, 8'h74); send(8'hE0); send(8'hE0); send(8'h74); idle(2);
    expect_ev(1, 1, 8'h7A); send(8'hF0); send(8'hE0); send(8'h7A); idle(2);
    expect_ev(1, 1, 8'h6B); send(8'hE0); send(8'hF0); send(8'hF0); send(8'hE0); send(8'h6B); idle(2);
    expect_ev(0, 1, 8'h29); send(8'hF0); send(8'hF0); send(8'h29); idle(2);
    expect_ev(0, 0, 8'hAA); send(8'hAA);
    expect_ev(0, 0, 8'hE1); send(8'hE1);
    expect_ev(0, 0, 8'hFA); send(8'hFA); idle(3);

    // Prefix discarded after TMO idle cycles; kept when the tick lands on the last one
    expect_ev(0, 0, 8'h1C); send(8'hE0); idle(TMO); send(8'h1C); idle(2);
    expect_ev(1, 0, 8'h75); send(8'hE0); idle(TMO - 1); send(8'h75); idle(2);
    check("empty_code", {key_ext, key_brk, key_code}, 0);

    // Overflow: four fill the FIFO, fifth is dropped
    key_ready = 1'b0;
    expect_ev(0, 0, 8'h15); send(8'h15);
    expect_ev(0, 0, 8'h16); send(8'h16);
    expect_ev(0, 0, 8'h17); send(8'h17);
    check("rx_en_not_full", rx_en, 1);
    expect_ev(0, 0, 8'h18); send(8'h18);
    check("rx_en_full", rx_en, 0);
    check("overflow_before_drop", overflow, 0);
    send(8'h19);
    check("overflow_set", overflow, 1);
    check("head_after_drop", key_code, 8'h15);
    key_ready = 1'b1;
    idle(6);
    check("rx_en_drained", rx_en, 1);
    check("valid_drained", key_valid, 0);
    check("overflow_sticky", overflow, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset mid-sequence drops the pending prefix and clears overflow
    send(8'hE0); send(8'hF0);
    reset = 1'b1; idle(2); reset = 1'b0;
    check("overflow_cleared", overflow, 0);
    expect_ev(0, 0, 8'h1C); send(8'h1C); idle(2);

    // Push into a full FIFO while the head is popped in the same cycle
    key_ready = 1'b0;
    expect_ev(0, 0, 8'h31); send(8'h31);
    expect_ev(0, 0, 8'h32); send(8'h32);
    expect_ev(0, 0, 8'h33); send(8'h33);
    expect_ev(0, 0, 8'h34); send(8'h34);
    key_ready = 1'b1;
    expect_ev(0, 0, 8'h2A); send(8'h2A);
    check("full_pop_push_rx_en", rx_en, 0);
    check("full_pop_push_overflow", overflow, 0);
    idle(6);
    check("final_valid", key_valid, 0);
    check("final_scoreboard", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
